uncached_store_buffer: RTL
==========================

// Module: uncached_store_buffer
// PURPOSE: Posted-write buffer between the uncached data port (sram-like, from d_confreg_port) and the AXI
//   write channels. It accepts uncached stores in one cycle and drains them in order, one AXI beat at a time,
//   so the pipeline no longer stalls on B responses. It exports a read-block signal that enforces read-after-write ordering.
// PARAMETERS: DEPTH 4 entries (power of two, >=2)
//   AW_W 32 address width; DW 32 data width; AXI fixed fields (awid/awlen/awburst/awlock/awcache/awprot/wid/wlast) tied at top level
// PORTS:
//   coreclock   in   1    core clock; all state on rising edge
//   areset_n    in   1    asynchronous active-low reset
//   sb_req      in   1    store request (write-only port)
//   sb_wen      in   4    byte strobes
//   sb_size     in   2    0=byte 1=half 2=word
//   sb_addr     in   32   physical address
//   sb_wdata    in   32   store data, lane-aligned
//   sb_addr_ok  out  1    request accepted this cycle (combinational: ~full)
//   sb_data_ok  out  1    one-cycle pulse, cycle after acceptance (posted completion)
//   rd_addr     in   32   address of pending uncached read
//   rd_block    out  1    read must be held back by arbiter
//   awaddr      out  32   head entry address
//   awsize      out  3    {1'b0,size}
//   awvalid     out  1    AW valid
//   awready     in   1    AW ready
//   wdata       out  32   head entry data
//   wstrb       out  4    head entry strobes
//   wvalid      out  1    W valid
//   wready      in   1    W ready
//   bresp       in   2    write response
//   bvalid      in   1    B valid
//   bready      out  1    B ready
//   bus_err     out  1    one-cycle pulse when bresp[1]==1
// BEHAVIOUR:
//   Reset: FIFO empty, ptrs/count 0, FSM IDLE; awvalid=wvalid=bready=sb_data_ok=bus_err=0, rd_block=0.
//   Push: sb_req&sb_addr_ok writes tail; count++. Full -> addr_ok=0, no push even if pop same cycle.
//   Push+pop same cycle (not full): count unchanged; ptrs wrap modulo DEPTH.
//   FSM IDLE: count!=0 -> SEND (earliest 1 cycle after push; no same-cycle bypass).
//   SEND: awvalid,wvalid held until each handshakes; aw_done/w_done tracked independently (either order,
//     or both same cycle); awaddr/wdata stable while valid. Both done -> WAIT_B.
//   WAIT_B: bready=1; on bvalid pop head, bus_err=bresp[1]; -> SEND if count>1 else IDLE. One outstanding write.
//   Error responses do not retry; entry still retired.
//   rd_block=1 whenever count!=0 (default; see CONFIGURATION). Head entry stays counted until B received.
//   Reset mid-burst: immediate clear, all valids drop; in-flight entries discarded.
// CONFIGURATION: macro UNCACHED_SB_RAW_MATCH_EN.
//   Defined: rd_block=1 only if some valid entry has addr[31:2]==rd_addr[31:2]; unrelated reads pass.
//   Undefined: rd_block = (count!=0), strict MMIO ordering; no comparators synthesised.
// STRUCTURE: shared package (defines.h): SB_SIZE_* codes, FSM state encoding (IDLE/SEND/WAIT_B), AXI fixed-field values.
//   One sub-module: sb_fifo (DEPTH x {addr,size,wen,wdata}, ptrs, count, full/empty, per-entry valid vector).
//   Top level holds the AXI FSM, done flags, rd_block logic.
// TESTING:
//   1) Store 0xBFAF_F000<-0x1234_5678 wen=F, awready=wready=1, B after 2 cyc -> addr_ok same cyc, data_ok +1,
//      awaddr=0xBFAFF000, awsize=2, wstrb=F, pop on bvalid, count 0.
//   2) 5 back-to-back stores, awready=0 -> 4 accepted, 5th addr_ok=0 until first B; AXI order = issue order.
//   3) awready before wready by 3 cyc, then reverse -> awvalid/wvalid drop independently, exactly one beat each.
//   4) bresp=2'b10 -> bus_err pulse 1 cycle, entry retired, next entry issued.
//   5) pending 0xBFD0_0000, rd_addr=0xBFD0_F000 -> rd_block=1 (macro off), 0 (macro on); rd_addr=0xBFD0_0000 -> 1 both.
//   6) areset_n low during SEND -> next cycle valids 0, count 0, rd_block 0; fresh store drains normally.

Source files
------------

// File: rtl/uncached_store_buffer_pkg.sv
// Shared definitions for the uncached store buffer.
//   - SB_SIZE_* : store size codes on the sram-like port.
//   - sb_state_e: AXI write FSM encoding (IDLE / SEND / WAIT_B).
//   - AXI_*     : constant AXI3 write-channel fields, all drains are
//                 single-beat, non-cacheable, unprivileged accesses.
//   - sb_axi_size: maps a store size code onto AXI awsize.
package uncached_store_buffer_pkg;

  localparam logic [1:0] SB_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SB_SIZE_HALF = 2'd1;
  localparam logic [1:0] SB_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    SB_IDLE   = 2'd0,
    SB_SEND   = 2'd1,
    SB_WAIT_B = 2'd2
  } sb_state_e;

  localparam logic [3:0] AXI_AWID    = 4'd1;
  localparam logic [3:0] AXI_AWLEN   = 4'd0;     // single beat
  localparam logic [1:0] AXI_AWBURST = 2'b01;    // INCR
  localparam logic [1:0] AXI_AWLOCK  = 2'b00;
  localparam logic [3:0] AXI_AWCACHE = 4'b0000;  // device, non-bufferable
  localparam logic [2:0] AXI_AWPROT  = 3'b000;
  localparam logic [3:0] AXI_WID     = 4'd1;
  localparam logic       AXI_WLAST   = 1'b1;

  function automatic logic [2:0] sb_axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/uncached_store_buffer_fifo.sv
// sb_fifo: in-order storage for posted uncached stores.
//   Ports: clk/rst_n (async active-low); push + push_* fields write the
//   tail; pop retires the head; head_* present the oldest entry; full,
//   empty and count give occupancy; entry_valid/entry_addr expose every
//   slot so the top level can look for address matches.
//   A push while full or a pop while empty is ignored, so a push is
//   refused when full even if the head is retired in the same cycle.
module uncached_store_buffer_fifo #(
  parameter int DEPTH = 4,
  parameter int AW_W  = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [AW_W-1:0]            push_addr,
  input  logic [1:0]                 push_size,
  input  logic [3:0]                 push_wen,
  input  logic [DW-1:0]              push_wdata,
  input  logic                       pop,
  output logic [AW_W-1:0]            head_addr,
  output logic [1:0]                 head_size,
  output logic [3:0]                 head_wen,
  output logic [DW-1:0]              head_wdata,
  output logic                       full,
  output logic                       empty,
  output logic [CW-1:0]              count,
  output logic [DEPTH-1:0]           entry_valid,
  output logic [DEPTH-1:0][AW_W-1:0] entry_addr
);

  logic [DEPTH-1:0][AW_W-1:0] addr_mem;
  logic [DEPTH-1:0][1:0]      size_mem;
  logic [DEPTH-1:0][3:0]      wen_mem;
  logic [DEPTH-1:0][DW-1:0]   data_mem;
  logic [PW-1:0]              wptr;
  logic [PW-1:0]              rptr;
  logic                       do_push;
  logic                       do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (do_push) begin
        wptr              <= wptr + 1'b1;
        entry_valid[wptr] <= 1'b1;
      end
      if (do_pop) begin
        rptr              <= rptr + 1'b1;
        entry_valid[rptr] <= 1'b0;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage needs no reset: entry_valid/count qualify it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wptr] <= push_addr;
      size_mem[wptr] <= push_size;
      wen_mem[wptr]  <= push_wen;
      data_mem[wptr] <= push_wdata;
    end
  end

  assign head_addr  = addr_mem[rptr];
  assign head_size  = size_mem[rptr];
  assign head_wen   = wen_mem[rptr];
  assign head_wdata = data_mem[rptr];
  assign entry_addr = addr_mem;

endmodule

// File: rtl/uncached_store_buffer.sv
// uncached_store_buffer: posted-write buffer between the uncached sram-like
// data port and the AXI write channels.
//   Store port : sb_req/sb_wen/sb_size/sb_addr/sb_wdata in; sb_addr_ok
//                (= not full, combinational), sb_data_ok (pulse the cycle
//                after acceptance).
//   Read order : rd_addr in, rd_block out.
//   AXI write  : aw*/w*/b* channels, fixed fields tied to constants;
//                bus_err pulses in the B handshake cycle when bresp[1]=1.
//   Debug      : sb_state (FSM state), sb_count (buffer occupancy).
//   Build option: UNCACHED_SB_RAW_MATCH_EN -- when defined rd_block only
//   asserts for a buffered store to the same word as rd_addr; otherwise
//   any buffered store blocks reads (strict MMIO ordering).
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid and its payload stay stable until that edge, and
// valid never depends on ready.
module uncached_store_buffer
  import uncached_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW_W  = 32,
  parameter int DW    = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            coreclock,
  input  logic            areset_n,
  input  logic            sb_req,
  input  logic [3:0]      sb_wen,
  input  logic [1:0]      sb_size,
  input  logic [AW_W-1:0] sb_addr,
  input  logic [DW-1:0]   sb_wdata,
  output logic            sb_addr_ok,
  output logic            sb_data_ok,
  input  logic [AW_W-1:0] rd_addr,
  output logic            rd_block,
  output logic [3:0]      awid,
  output logic [AW_W-1:0] awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [3:0]      wid,
  output logic [DW-1:0]   wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  output logic            bus_err,
  output logic [1:0]      sb_state,
  output logic [CW-1:0]   sb_count
);

  sb_state_e                  state_q, state_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic                       data_ok_q;
  logic                       push;
  logic                       pop;
  logic                       aw_fire;
  logic                       w_fire;
  logic                       full;
  logic                       empty;
  logic [CW-1:0]              count;
  logic [1:0]                 head_size;
  logic [DEPTH-1:0]           entry_valid;
  logic [DEPTH-1:0][AW_W-1:0] entry_addr;
  logic                       unused_bits;

  assign push       = sb_req & ~full;
  assign pop        = bready & bvalid;
  assign sb_addr_ok = ~full;
  assign sb_data_ok = data_ok_q;
  assign aw_fire    = awvalid & awready;
  assign w_fire     = wvalid & wready;

  uncached_store_buffer_fifo #(
    .DEPTH (DEPTH),
    .AW_W  (AW_W),
    .DW    (DW)
  ) u_fifo (
    .clk         (coreclock),
    .rst_n       (areset_n),
    .push        (push),
    .push_addr   (sb_addr),
    .push_size   (sb_size),
    .push_wen    (sb_wen),
    .push_wdata  (sb_wdata),
    .pop         (pop),
    .head_addr   (awaddr),
    .head_size   (head_size),
    .head_wen    (wstrb),
    .head_wdata  (wdata),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // State register, per-channel done flags and the posted completion.
  always_ff @(posedge coreclock or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= SB_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= push;
    end
  end

  // Next state. AW and W complete independently and in either order;
  // only one write is outstanding, so B always belongs to the head.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      SB_IDLE: begin
        if (!empty) state_d = SB_SEND;
      end
      SB_SEND: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d   = SB_WAIT_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      SB_WAIT_B: begin
        // count still includes the head being retired this cycle.
        if (bvalid) state_d = (count > CW'(1)) ? SB_SEND : SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state_q)
      SB_SEND: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
      SB_WAIT_B: bready = 1'b1;
      default: ;
    endcase
  end

  // Error responses are reported but never retried.
  assign bus_err = pop & bresp[1];

  assign awid    = AXI_AWID;
  assign awlen   = AXI_AWLEN;
  assign awsize  = sb_axi_size(head_size);
  assign awburst = AXI_AWBURST;
  assign awlock  = AXI_AWLOCK;
  assign awcache = AXI_AWCACHE;
  assign awprot  = AXI_AWPROT;
  assign wid     = AXI_WID;
  assign wlast   = AXI_WLAST;

  assign sb_state = state_q;
  assign sb_count = count;

`ifdef UNCACHED_SB_RAW_MATCH_EN
  // Word-granular match: any buffered store to the same word blocks.
  logic [DEPTH-1:0] hit;
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = entry_valid[i] && (entry_addr[i][AW_W-1:2] == rd_addr[AW_W-1:2]);
    end
  end
  assign rd_block    = |hit;
  assign unused_bits = ^{bresp[0], rd_addr[1:0]};
`else
  assign rd_block    = ~empty;
  assign unused_bits = ^{bresp[0], rd_addr, entry_valid, entry_addr};
`endif

endmodule
